mux_arbiter: RTL and testbench
==============================

// Module: mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one mux instance between N requesters.
//  Grants one requester at a time, drives the mux select, and produces a valid/source tag aligned with mux output latency.
//  Sits directly in front of mux; gnt_o returns to requesters, sel_o feeds mux sel_i, vld_o/src_o travel with mux res_o.
// PARAMETERS
//  N       2   number of requesters (>=1); also width of sel_o, matching mux sel_i
//  IREG    1   must equal the mux IREG setting (0/1); sets the alignment delay
//  OREG    1   must equal the mux OREG setting (0/1); sets the alignment delay
//  MAXHOLD 16  max consecutive grant cycles per tenure; 0 = unlimited
// PORTS
//  clk_i   in   1  clock; all state changes on rising edge
//  rst_i   in   1  asynchronous, active-high reset
//  ce_i    in   1  clock enable, shared with the mux; low = every register holds
//  req_i   in   N  request per requester; held high for the whole transfer
//  gnt_o   out  N  one-hot grant (or all zero), registered
//  sel_o   out  N  binary index of current owner, zero-extended to N bits; wire to mux sel_i
//  busy_o  out  1  high while any grant is active
//  vld_o   out  1  mux res_o carries granted data this cycle
//  src_o   out  N  one-hot owner tag aligned with vld_o; zero when vld_o=0
// BEHAVIOUR
//  Reset (async, immediate): gnt_o=0, sel_o=0, busy_o=0, vld_o=0, src_o=0; ptr=0; hold cnt=0; state IDLE; delay line cleared.
//   Reset asserted mid-tenure drops the grant in the same cycle, without waiting for a clock edge.
//  ce_i=0: state, ptr, cnt, outputs and delay line all freeze. Inputs are ignored for that cycle.
//  States: IDLE (no owner), GRANT (owner held in register).
//  Pick function: first set req_i bit at index >= ptr, searching upward and wrapping modulo N.
//  IDLE: when |req_i=1, the picked requester is granted at the next edge (req->gnt latency 1 cycle); go to GRANT, cnt=0.
//  GRANT: keep owner while req_i[owner]=1 and (MAXHOLD==0 or cnt<MAXHOLD-1); cnt increments each enabled cycle.
//  Release: when req_i[owner]=0 or the hold limit is reached, ptr=(owner+1) mod N.
//   If another request is pending, re-pick with the new ptr in the same edge, so there is no idle gap.
//   If no request is pending: gnt_o=0 and go to IDLE.
//   If the owner still requests after hold expiry and no one else does, re-grant the owner immediately with cnt=0.
//  Invariants: gnt_o is always one-hot or zero; sel_o==index(gnt_o) while busy_o=1; sel_o holds its last value when idle.
//  Requests arriving at the same time: the rotating pointer decides. The just-released owner has lowest priority.
//  A requester dropping req_i without holding a grant has no effect.
//  Alignment: LAT=IREG+OREG. vld_o/src_o equal |gnt_o / gnt_o delayed by LAT enabled cycles.
//   LAT=0 makes them combinational copies of the registered grant.
//  N=1: ptr is fixed at 0; sel_o=0 always; the hold limit still forces a 1-cycle-free re-grant (cnt reset).
// STRUCTURE
//  Shared include util.vh: clog2 function; state encodings as localparams ST_IDLE/ST_GRANT.
//  Sub-module rr_pick (combinational):
//   inputs req[N] and ptr index; outputs one-hot pick and binary index.
//   Implemented as a double-width rotate-and-priority-encode.
//  Top module holds the state register, ptr, hold counter and LAT-deep delay line (generate over LAT).
// TESTING
//  1. Reset then req_i=2'b01 held 5 cycles -> gnt_o=01 from cycle 1 to cycle 5; vld_o high cycles 3..7 (IREG=OREG=1); gnt_o=00 after drop.
//  2. req_i=2'b11 from reset -> gnt 01 first. Drop req0 -> gnt 10 on the next edge with no gap. Re-raise req0 -> served after req1 drops.
//  3. MAXHOLD=4, N=3, req_i=3'b111 constant -> grants rotate 001,010,100,001, each exactly 4 cycles; sel_o cycles 0,1,2.
//  4. ce_i low 3 cycles during grant -> gnt_o, cnt and vld_o pipeline frozen. Resume -> tenure ends 3 cycles later than with ce_i high throughout.
//  5. rst_i pulsed mid-grant (asynchronous, between edges) -> gnt_o, vld_o, src_o go to 0 immediately; after release, a pending req3 is picked from ptr=0.
//  6. IREG=0, OREG=0 -> vld_o/src_o equal |gnt_o/gnt_o in the same cycle. A scoreboard checks mux res_o equals op_i[owner] on every vld_o.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin mux arbiter.
// Owner state encoding and index-width arithmetic used by the top and its picker.
package mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < value) r++;
    return r;
  endfunction

  // Index registers must be at least one bit wide, even for a single requester.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Rotates a doubled request vector by ptr_i, then priority-encodes the lowest set bit.
module rr_pick
  import mux_arbiter_pkg::*;
#(
  parameter int N    = 2,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    sum;

  always_comb begin
    dbl    = {req_i, req_i} >> ptr_i;
    rot    = dbl[N-1:0];
    any_o  = |req_i;
    idx_o  = '0;
    sum    = 0;
    // Walk from the top so the lowest rotated position is the last one to win.
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[N-1-i]) begin
        sum = int'(ptr_i) + (N - 1 - i);
        if (sum >= N) sum = sum - N;
        idx_o = IDXW'(sum);
      end
    end
    pick_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one mux between N requesters, with a valid/source
// tag delayed by IREG+OREG enabled cycles to line up with the mux result.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int IREG    = 1,
  parameter int OREG    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [N-1:0] sel_o,
  output logic         busy_o,
  output logic         vld_o,
  output logic [N-1:0] src_o
);

  localparam int IDXW = idx_width(N);
  localparam int LAT  = IREG + OREG;
  localparam int CNTW = (MAXHOLD < 2) ? 1 : clog2(MAXHOLD);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [IDXW-1:0] pick_ptr;
  logic [IDXW-1:0] pick_idx;
  logic [N-1:0]    pick_gnt;
  logic            pick_any;
  logic [IDXW-1:0] next_ptr;
  logic            hold_ok;
  logic            keep;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (pick_ptr),
    .pick_o (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else if (ce_i) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // In GRANT the picker looks from owner+1, so a release can hand over in the
  // same edge and the outgoing owner naturally ranks last.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    next_ptr = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + IDXW'(1);
    hold_ok  = (MAXHOLD == 0) || (int'(cnt_q) < MAXHOLD - 1);
    keep     = 1'b0;
    pick_ptr = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        pick_ptr = next_ptr;
        keep     = req_i[owner_q] && hold_ok;
        if (keep) begin
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_any) begin
            gnt_d   = pick_gnt;
            owner_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = gnt_q;
    sel_o  = N'(owner_q);
    busy_o = (state_q == ST_GRANT);
  end

  generate
    if (LAT == 0) begin : g_nodly
      always_comb begin
        vld_o = |gnt_q;
        src_o = gnt_q;
      end
    end else begin : g_dly
      logic [N-1:0] dly_q [LAT];
      logic [N-1:0] dly_d [LAT];

      always_comb begin
        dly_d[0] = gnt_q;
        for (int unsigned i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int unsigned i = 0; i < LAT; i++) dly_q[i] <= '0;
        end else if (ce_i) begin
          for (int unsigned i = 0; i < LAT; i++) dly_q[i] <= dly_d[i];
        end
      end

      always_comb begin
        src_o = dly_q[LAT-1];
        vld_o = |dly_q[LAT-1];
      end
    end
  endgenerate

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: vector table for the 2-requester default build,
// plus hand sequences for hold-limit rotation, zero-latency alignment and async reset.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b1;

  always #5 clk = ~clk;

  logic [1:0] req_a, gnt_a, sel_a, src_a;
  logic       busy_a, vld_a;
  logic [2:0] req_b, gnt_b, sel_b, src_b;
  logic       busy_b, vld_b;
  logic [3:0] req_c, gnt_c, sel_c, src_c;
  logic       busy_c, vld_c;

  logic [7:0] op_b [3];
  logic [7:0] res_b;

  int errors = 0;
  int checks = 0;

  mux_arbiter #(.N(2), .IREG(1), .OREG(1), .MAXHOLD(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req_a), .gnt_o(gnt_a),
    .sel_o(sel_a), .busy_o(busy_a), .vld_o(vld_a), .src_o(src_a)
  );

  mux_arbiter #(.N(3), .IREG(0), .OREG(0), .MAXHOLD(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req_b), .gnt_o(gnt_b),
    .sel_o(sel_b), .busy_o(busy_b), .vld_o(vld_b), .src_o(src_b)
  );

  mux_arbiter #(.N(4), .IREG(1), .OREG(0), .MAXHOLD(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req_c), .gnt_o(gnt_c),
    .sel_o(sel_c), .busy_o(busy_c), .vld_o(vld_c), .src_o(src_c)
  );

  // Zero-latency mux model fed by dut_b's select.
  always_comb res_b = (sel_b < 3'd3) ? op_b[sel_b[1:0]] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       ce;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [1:0] src;
  } vec_t;

  vec_t tbl [26];

  initial begin
    // rst, ce, req, gnt, sel, vld, src
    tbl[0]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b01};
    tbl[3]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b01};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b01};
    tbl[5]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b1, 2'b01};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b1, 2'b01};
    tbl[7]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 2'b00};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 2'b01, 2'd0, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 2'b11, 2'b01, 2'd0, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'd1, 1'b1, 2'b01};
    tbl[11] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'd1, 1'b1, 2'b01};
    tbl[12] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'd1, 1'b1, 2'b10};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b10};
    tbl[14] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b10};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 1'b1, 2'b10};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 1'b1, 2'b10};
    tbl[17] = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 1'b1, 2'b10};
    tbl[18] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'd0, 1'b1, 2'b01};
    tbl[19] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b1, 2'b01};
    tbl[20] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b1, 2'b01};
    tbl[21] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 2'b00};
    tbl[22] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'd1, 1'b0, 2'b00};
    tbl[23] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 1'b0, 2'b00};
    tbl[24] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 1'b1, 2'b10};
    tbl[25] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 1'b0, 2'b00};

    req_a = '0;
    req_b = '0;
    req_c = '0;
    for (int i = 0; i < 3; i++) op_b[i] = 8'h00;

    #1 rst = 1'b1;
    #2;
    chk("reset gnt", gnt_a, 0);
    chk("reset sel", sel_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset vld", vld_a, 0);
    chk("reset src", src_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester, pair handover, late re-request, clock-enable freeze.
    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      ce    = tbl[i].ce;
      req_a = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d gnt", i), gnt_a, tbl[i].gnt);
      chk($sformatf("vec%0d sel", i), sel_a, tbl[i].sel);
      chk($sformatf("vec%0d busy", i), busy_a, tbl[i].gnt != 2'b00);
      chk($sformatf("vec%0d vld", i), vld_a, tbl[i].vld);
      chk($sformatf("vec%0d src", i), src_a, tbl[i].src);
    end
    req_a = '0;
    ce    = 1'b1;

    // Hold limit of 4 with all three requesting: strict 4-cycle rotation, zero latency tag.
    rst = 1'b1;
    #1 rst = 1'b0;
    req_b = 3'b111;
    for (int k = 0; k < 13; k++) begin
      int          idx;
      logic [2:0]  eg;
      idx = (k / 4) % 3;
      eg  = 3'b001 << idx;
      for (int i = 0; i < 3; i++) op_b[i] = 8'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("rot%0d gnt", k), gnt_b, eg);
      chk($sformatf("rot%0d sel", k), sel_b, idx);
      chk($sformatf("rot%0d vld", k), vld_b, 1);
      chk($sformatf("rot%0d src", k), src_b, eg);
      chk($sformatf("rot%0d res", k), res_b, op_b[idx]);
    end
    req_b = '0;
    @(posedge clk);
    #1;
    chk("rot idle vld", vld_b, 0);
    chk("rot idle src", src_b, 0);

    // Async reset mid-tenure after the pointer has moved away from 0.
    req_c = 4'b0010;
    @(posedge clk);
    #1;
    chk("ar first gnt", gnt_c, 4'b0010);
    req_c = 4'b1000;
    @(posedge clk);
    #1;
    chk("ar handover gnt", gnt_c, 4'b1000);
    chk("ar handover src", src_c, 4'b0010);
    chk("ar handover vld", vld_c, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar async gnt", gnt_c, 0);
    chk("ar async vld", vld_c, 0);
    chk("ar async src", src_c, 0);
    chk("ar async busy", busy_c, 0);
    req_c = 4'b1010;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ar repick gnt", gnt_c, 4'b0010);
    chk("ar repick sel", sel_c, 1);
    chk("ar repick vld", vld_c, 0);
    @(posedge clk);
    #1;
    chk("ar hold gnt", gnt_c, 4'b0010);
    chk("ar hold src", src_c, 4'b0010);
    req_c = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
